// File: rtl/text_console_writer.sv
// Terminal write engine: UART bytes -> character-buffer cell writes with cursor and CR/LF/BS/FF handling.
// Optional blinking cursor phase output enabled by defining TEXT_CON_CURSOR_EN.
module text_console_writer #(
    parameter int                NCOL      = 80,
    parameter int                NROW      = 30,
    parameter int                CHAR_W    = 7,
    parameter logic [CHAR_W-1:0] FILL_CHAR = 7'h20,
`ifdef TEXT_CON_CURSOR_EN
    parameter int                BLINK_DIV = 12500000,
`endif
    localparam int               COL_W     = $clog2(NCOL),
    localparam int               ROW_W     = $clog2(NROW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [COL_W-1:0]  col_w,
    output logic [ROW_W-1:0]  row_w,
    output logic [CHAR_W-1:0] din,
    output logic              busy,
    output logic [COL_W-1:0]  cur_col,
    output logic [ROW_W-1:0]  cur_row,
`ifdef TEXT_CON_CURSOR_EN
    output logic              cursor_on,
`endif
    output logic              rx_overrun
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(NCOL - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NROW - 1);

    logic [0:0]       state;
    logic [COL_W-1:0] sweep_col;
    logic [ROW_W-1:0] sweep_row;
    logic             sweep_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            sweep_col  <= '0;
            sweep_row  <= '0;
            sweep_end  <= 1'b0;
            wr_en      <= 1'b0;
            col_w      <= '0;
            row_w      <= '0;
            din        <= FILL_CHAR;
            busy       <= 1'b1;
            cur_col    <= '0;
            cur_row    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (state == S_CLEAR) begin
                if (rx_valid)
                    rx_overrun <= 1'b1;
                // sweep_end marks the cycle after the final cell write
                if (sweep_end) begin
                    sweep_end <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                    cur_col   <= '0;
                    cur_row   <= '0;
                end else begin
                    wr_en <= 1'b1;
                    col_w <= sweep_col;
                    row_w <= sweep_row;
                    din   <= FILL_CHAR;
                    if (sweep_col == COL_MAX) begin
                        sweep_col <= '0;
                        if (sweep_row == ROW_MAX) begin
                            sweep_row <= '0;
                            sweep_end <= 1'b1;
                        end else begin
                            sweep_row <= sweep_row + ROW_W'(1);
                        end
                    end else begin
                        sweep_col <= sweep_col + COL_W'(1);
                    end
                end
            end else if (rx_valid && !rx_data[7]) begin
                if (rx_data >= 8'h20 && rx_data != 8'h7F) begin
                    wr_en <= 1'b1;
                    col_w <= cur_col;
                    row_w <= cur_row;
                    din   <= rx_data[CHAR_W-1:0];
                    if (cur_col == COL_MAX) begin
                        cur_col <= '0;
                        cur_row <= (cur_row == ROW_MAX) ? '0 : cur_row + ROW_W'(1);
                    end else begin
                        cur_col <= cur_col + COL_W'(1);
                    end
                end else if (rx_data == 8'h0D) begin
                    cur_col <= '0;
                end else if (rx_data == 8'h0A) begin
                    cur_row <= (cur_row == ROW_MAX) ? '0 : cur_row + ROW_W'(1);
                end else if (rx_data == 8'h08) begin
                    if (cur_col != '0) begin
                        cur_col <= cur_col - COL_W'(1);
                        wr_en   <= 1'b1;
                        col_w   <= cur_col - COL_W'(1);
                        row_w   <= cur_row;
                        din     <= FILL_CHAR;
                    end
                end else if (rx_data == 8'h0C) begin
                    state     <= S_CLEAR;
                    busy      <= 1'b1;
                    sweep_col <= '0;
                    sweep_row <= '0;
                    sweep_end <= 1'b0;
                end
            end
        end
    end

`ifdef TEXT_CON_CURSOR_EN
    localparam int BL_W = $clog2(BLINK_DIV + 1);

    logic [BL_W-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst || busy) begin
            blink_cnt <= '0;
            cursor_on <= 1'b0;
        end else if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            cursor_on <= ~cursor_on;
        end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer (80x30, 7-bit chars).
module tb_text_console_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wr_en;
    logic [6:0] col_w;
    logic [4:0] row_w;
    logic [6:0] din;
    logic       busy;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       rx_overrun;
`ifdef TEXT_CON_CURSOR_EN
    logic       cursor_on;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    text_console_writer #(
        .NCOL(80), .NROW(30), .CHAR_W(7), .FILL_CHAR(7'h20)
`ifdef TEXT_CON_CURSOR_EN
        , .BLINK_DIV(4)
`endif
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .wr_en(wr_en), .col_w(col_w), .row_w(row_w), .din(din), .busy(busy),
        .cur_col(cur_col), .cur_row(cur_row),
`ifdef TEXT_CON_CURSOR_EN
        .cursor_on(cursor_on),
`endif
        .rx_overrun(rx_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the strobe is consumed by the following posedge.
    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Samples from the current negedge until busy falls, checking raster order.
    task automatic sweep_watch(output int nbusy, output int nwr, output int nerr,
                               output int last_c, output int last_r);
        int ec, er;
        ec = 0; er = 0; nbusy = 0; nwr = 0; nerr = 0; last_c = -1; last_r = -1;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            nbusy++;
            if (wr_en) begin
                nwr++;
                if (col_w != 7'(ec) || row_w != 5'(er) || din != 7'h20) nerr++;
                last_c = int'(col_w);
                last_r = int'(row_w);
                if (ec == 79) begin ec = 0; er = (er == 29) ? 0 : er + 1; end
                else ec++;
            end
            @(negedge clk);
        end
        check("sweep_finished", {31'd0, busy}, 32'd0);
    endtask

    int nbusy, nwr, nerr, lc, lr;

    initial begin
        // 1: reset and power-up clear
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_din", {25'd0, din}, 32'h20);
        check("rst_col_w", {25'd0, col_w}, 32'd0);
        check("rst_row_w", {27'd0, row_w}, 32'd0);
        check("rst_cursor", {20'd0, cur_col, cur_row}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
`ifdef TEXT_CON_CURSOR_EN
        check("rst_cursor_on", {31'd0, cursor_on}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        sweep_watch(nbusy, nwr, nerr, lc, lr);
        check("clr_busy_cycles", nbusy, 2400);
        check("clr_writes", nwr, 2400);
        check("clr_order", nerr, 0);
        check("clr_last_col", lc, 79);
        check("clr_last_row", lr, 29);
        check("clr_cur_col", {25'd0, cur_col}, 32'd0);
        check("clr_cur_row", {27'd0, cur_row}, 32'd0);
        check("clr_wr_en_off", {31'd0, wr_en}, 32'd0);
`ifdef TEXT_CON_CURSOR_EN
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("blink_hold", {31'd0, cursor_on}, 32'd0);
        @(negedge clk);
        check("blink_on", {31'd0, cursor_on}, 32'd1);
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("blink_on_hold", {31'd0, cursor_on}, 32'd1);
        @(negedge clk);
        check("blink_off", {31'd0, cursor_on}, 32'd0);
`endif

        // 2: single printable, then a high-bit byte
        put(8'h41);
        check("a_wr_en", {31'd0, wr_en}, 32'd1);
        check("a_col_w", {25'd0, col_w}, 32'd0);
        check("a_row_w", {27'd0, row_w}, 32'd0);
        check("a_din", {25'd0, din}, 32'h41);
        check("a_cur_col", {25'd0, cur_col}, 32'd1);
        @(negedge clk);
        check("a_wr_en_drop", {31'd0, wr_en}, 32'd0);
        put(8'hC1);
        check("hi_no_write", {31'd0, wr_en}, 32'd0);
        check("hi_cur_col", {25'd0, cur_col}, 32'd1);
        put(8'h0D);
        check("cr_home", {25'd0, cur_col}, 32'd0);

        // 3: fill a row back-to-back, then wrap from the last cell
        nwr = 0; nerr = 0;
        for (int i = 0; i < 80; i++) begin
            put(8'h42);
            if (wr_en) begin
                nwr++;
                if (col_w != 7'(i) || row_w != 5'd0 || din != 7'h42) nerr++;
            end
        end
        check("row_writes", nwr, 80);
        check("row_order", nerr, 0);
        check("row_last_col", {25'd0, col_w}, 32'd79);
        check("row_cur", {20'd0, cur_col, cur_row}, {20'd0, 7'd0, 5'd1});
        for (int i = 0; i < 28; i++) put(8'h0A);
        for (int i = 0; i < 79; i++) put(8'h42);
        check("pre_wrap_cur", {20'd0, cur_col, cur_row}, {20'd0, 7'd79, 5'd29});
        put(8'h43);
        check("wrap_wr", {31'd0, wr_en}, 32'd1);
        check("wrap_pos", {20'd0, col_w, row_w}, {20'd0, 7'd79, 5'd29});
        check("wrap_din", {25'd0, din}, 32'h43);
        check("wrap_cur", {20'd0, cur_col, cur_row}, 32'd0);

        // 4: CR/LF, backspace at col 0 and col 2, ignored codes
        for (int i = 0; i < 3; i++) put(8'h0A);
        for (int i = 0; i < 5; i++) put(8'h45);
        check("at_5_3", {20'd0, cur_col, cur_row}, {20'd0, 7'd5, 5'd3});
        put(8'h0D);
        check("cr_no_write", {31'd0, wr_en}, 32'd0);
        put(8'h0A);
        check("lf_no_write", {31'd0, wr_en}, 32'd0);
        check("crlf_cur", {20'd0, cur_col, cur_row}, {20'd0, 7'd0, 5'd4});
        put(8'h08);
        check("bs0_no_write", {31'd0, wr_en}, 32'd0);
        check("bs0_cur", {20'd0, cur_col, cur_row}, {20'd0, 7'd0, 5'd4});
        put(8'h07);
        put(8'h7F);
        check("ign_no_write", {31'd0, wr_en}, 32'd0);
        check("ign_cur", {20'd0, cur_col, cur_row}, {20'd0, 7'd0, 5'd4});
        put(8'h46);
        put(8'h46);
        put(8'h08);
        check("bs_wr", {31'd0, wr_en}, 32'd1);
        check("bs_pos", {20'd0, col_w, row_w}, {20'd0, 7'd1, 5'd4});
        check("bs_din", {25'd0, din}, 32'h20);
        check("bs_cur", {20'd0, cur_col, cur_row}, {20'd0, 7'd1, 5'd4});

        // 5: form feed with a byte arriving during the sweep
        check("ovr_before", {31'd0, rx_overrun}, 32'd0);
        put(8'h0C);
        check("ff_busy", {31'd0, busy}, 32'd1);
        check("ff_no_write", {31'd0, wr_en}, 32'd0);
        put(8'h44);
        sweep_watch(nbusy, nwr, nerr, lc, lr);
        check("ff_writes", nwr, 2400);
        check("ff_all_fill", nerr, 0);
        check("ff_overrun", {31'd0, rx_overrun}, 32'd1);
        check("ff_cur", {20'd0, cur_col, cur_row}, 32'd0);

        // 6: reset in the middle of a sweep
        put(8'h0C);
        for (int i = 0; i < 1000; i++) @(negedge clk);
        check("mid_sweep_wr", {31'd0, wr_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("mid_rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("restart_pos", {19'd0, wr_en, col_w, row_w}, {19'd0, 1'b1, 7'd0, 5'd0});
        sweep_watch(nbusy, nwr, nerr, lc, lr);
        check("restart_writes", nwr, 2400);
        check("restart_order", nerr, 0);
        check("restart_overrun", {31'd0, rx_overrun}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
